// File: rtl/vx_commit_pkg.sv
// Shared types for the commit gather path: commit payload, unit slots, arbiter state, popcount.
package vx_commit_pkg;

  localparam int unsigned CMT_NUM_UNITS = 4;
  localparam int unsigned NUM_THREADS   = 4;
  localparam int unsigned XLEN          = 32;
  localparam int unsigned NW_BITS       = 2;
  localparam int unsigned NR_BITS       = 6;
  localparam int unsigned UUID_W        = 44;
  localparam int unsigned CMT_CTR_W     = 64;
  localparam int unsigned TCNT_W        = $clog2(NUM_THREADS + 1);

  localparam int unsigned UNIT_ALU = 0;
  localparam int unsigned UNIT_LSU = 1;
  localparam int unsigned UNIT_FPU = 2;
  localparam int unsigned UNIT_SFU = 3;

  typedef struct packed {
    logic [UUID_W-1:0]                 uuid;
    logic [NW_BITS-1:0]                wid;
    logic [NUM_THREADS-1:0]            tmask;
    logic [XLEN-1:0]                   pc;
    logic                              wb;
    logic [NR_BITS-1:0]                rd;
    logic [NUM_THREADS-1:0][XLEN-1:0]  data;
    logic                              sop;
    logic                              eop;
  } commit_t;

  localparam int unsigned CMT_W = $bits(commit_t);

  typedef enum logic {
    ARB_OPEN   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  function automatic logic [TCNT_W-1:0] popcount(input logic [NUM_THREADS-1:0] mask);
    logic [TCNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < int'(NUM_THREADS); i++) begin
      cnt = cnt + TCNT_W'(mask[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/vx_commit_rr_arb.sv
// Round-robin arbiter with packet lock: a unit that starts a multi-beat result keeps the grant until eop.
module vx_commit_rr_arb
  import vx_commit_pkg::*;
#(
  parameter int unsigned NUM_UNITS = CMT_NUM_UNITS,
  parameter int unsigned UNIT_W    = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_UNITS-1:0] valid,
  input  logic                 fire,
  input  logic                 eop,
  output logic [NUM_UNITS-1:0] grant_c,
  output logic [UNIT_W-1:0]    grant_idx_c,
  output logic                 grant_valid_c
);

  arb_state_e        state_q, state_d;
  logic [UNIT_W-1:0] ptr_q, ptr_d;
  logic [UNIT_W-1:0] lock_q, lock_d;
  int unsigned       cand;

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ARB_OPEN;
      ptr_q   <= '0;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      lock_q  <= lock_d;
    end
  end

  // next state: only an accepted beat moves the pointer or the lock
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    lock_d  = lock_q;
    if (fire) begin
      if (eop) begin
        state_d = ARB_OPEN;
        ptr_d   = (grant_idx_c == UNIT_W'(NUM_UNITS - 1)) ? '0 : grant_idx_c + UNIT_W'(1);
      end else begin
        state_d = ARB_LOCKED;
        lock_d  = grant_idx_c;
      end
    end
  end

  // grant: locked unit only, otherwise first valid at or after the pointer
  always_comb begin
    grant_c       = '0;
    grant_idx_c   = '0;
    grant_valid_c = 1'b0;
    cand          = 0;
    if (state_q == ARB_LOCKED) begin
      if (valid[lock_q]) begin
        grant_valid_c = 1'b1;
        grant_idx_c   = lock_q;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_UNITS; i++) begin
        cand = 32'(ptr_q) + i;
        if (cand >= NUM_UNITS) cand = cand - NUM_UNITS;
        if (!grant_valid_c && valid[UNIT_W'(cand)]) begin
          grant_valid_c = 1'b1;
          grant_idx_c   = UNIT_W'(cand);
        end
      end
    end
    if (grant_valid_c) grant_c[grant_idx_c] = 1'b1;
  end

endmodule

// File: rtl/vx_commit_gather.sv
// Issue-slot commit gather: arbitrates unit results into a 2-entry output buffer and counts retired threads.
// Optional COMMIT_PERF_EN adds per-unit saturating stall counters on perf_stalls.
module vx_commit_gather
  import vx_commit_pkg::*;
#(
  parameter  int unsigned NUM_UNITS = CMT_NUM_UNITS,
  parameter  int unsigned CTR_W     = CMT_CTR_W,
  localparam int unsigned UNIT_W    = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_UNITS-1:0]         in_valid,
  output logic [NUM_UNITS-1:0]         in_ready,
  input  logic [NUM_UNITS*CMT_W-1:0]   in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CMT_W-1:0]             out_data,
  output logic [UNIT_W-1:0]            out_unit,
  output logic [CTR_W-1:0]             retired_cnt
`ifdef COMMIT_PERF_EN
  ,
  output logic [NUM_UNITS*CTR_W-1:0]   perf_stalls
`endif
);

  commit_t               in_cmt [NUM_UNITS];
  logic [NUM_UNITS-1:0]  grant_c;
  logic [UNIT_W-1:0]     grant_idx_c;
  logic                  grant_valid_c;
  logic                  fire_c;
  logic                  pop_c;

  commit_t               head_q, head_d, skid_q, skid_d;
  logic [UNIT_W-1:0]     head_unit_q, head_unit_d, skid_unit_q, skid_unit_d;
  logic                  head_valid_q, head_valid_d, skid_valid_q, skid_valid_d;
  logic                  room_q, room_d;
  logic [CTR_W-1:0]      retired_q, retired_d;

  for (genvar g = 0; g < NUM_UNITS; g++) begin : g_unpack
    assign in_cmt[g] = in_data[g*CMT_W +: CMT_W];
  end

  vx_commit_rr_arb #(
    .NUM_UNITS (NUM_UNITS),
    .UNIT_W    (UNIT_W)
  ) u_arb (
    .clk           (clk),
    .reset_n       (reset_n),
    .valid         (in_valid),
    .fire          (fire_c),
    .eop           (in_cmt[grant_idx_c].eop),
    .grant_c       (grant_c),
    .grant_idx_c   (grant_idx_c),
    .grant_valid_c (grant_valid_c)
  );

  // room_q is a registered "not full" so in_ready never sees out_ready combinationally
  assign in_ready = grant_c & {NUM_UNITS{room_q}};
  assign fire_c   = grant_valid_c & room_q;
  assign pop_c    = head_valid_q & out_ready;

  // head is the registered output stage, skid holds the second entry
  always_comb begin
    head_valid_d = head_valid_q;
    head_d       = head_q;
    head_unit_d  = head_unit_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    skid_unit_d  = skid_unit_q;
    if (!head_valid_q || pop_c) begin
      if (skid_valid_q) begin
        head_valid_d = 1'b1;
        head_d       = skid_q;
        head_unit_d  = skid_unit_q;
        skid_valid_d = fire_c;
        if (fire_c) begin
          skid_d      = in_cmt[grant_idx_c];
          skid_unit_d = grant_idx_c;
        end
      end else begin
        head_valid_d = fire_c;
        if (fire_c) begin
          head_d      = in_cmt[grant_idx_c];
          head_unit_d = grant_idx_c;
        end
      end
    end else if (fire_c) begin
      skid_valid_d = 1'b1;
      skid_d       = in_cmt[grant_idx_c];
      skid_unit_d  = grant_idx_c;
    end
    room_d    = !(head_valid_d && skid_valid_d);
    retired_d = retired_q;
    if (pop_c && head_q.eop) retired_d = retired_q + CTR_W'(popcount(head_q.tmask));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_valid_q <= 1'b0;
      head_q       <= '0;
      head_unit_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
      skid_unit_q  <= '0;
      room_q       <= 1'b0;
      retired_q    <= '0;
    end else begin
      head_valid_q <= head_valid_d;
      head_q       <= head_d;
      head_unit_q  <= head_unit_d;
      skid_valid_q <= skid_valid_d;
      skid_q       <= skid_d;
      skid_unit_q  <= skid_unit_d;
      room_q       <= room_d;
      retired_q    <= retired_d;
    end
  end

  assign out_valid   = head_valid_q;
  assign out_data    = head_q;
  assign out_unit    = head_unit_q;
  assign retired_cnt = retired_q;

`ifdef COMMIT_PERF_EN
  logic [CTR_W-1:0] stall_q [NUM_UNITS];

  // a cycle with valid but no accept is a stall; counters stick at all-ones
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_UNITS; i++) stall_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_UNITS; i++) begin
        if (in_valid[i] && !in_ready[i] && (stall_q[i] != '1)) stall_q[i] <= stall_q[i] + CTR_W'(1);
      end
    end
  end

  for (genvar g = 0; g < NUM_UNITS; g++) begin : g_perf
    assign perf_stalls[g*CTR_W +: CTR_W] = stall_q[g];
  end
`else
  // stall counters compiled out
`endif

endmodule

// File: tb/tb_vx_commit_gather.sv
// Directed bench for vx_commit_gather; perf checks run when COMMIT_PERF_EN is defined (counter width 4).
module tb_vx_commit_gather;
  import vx_commit_pkg::*;

`ifdef COMMIT_PERF_EN
  localparam int unsigned TB_CTR_W = 4;
`else
  localparam int unsigned TB_CTR_W = 64;
`endif
  localparam int unsigned NU = 4;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic [NU-1:0]         in_valid;
  logic [NU-1:0]         in_ready;
  logic [NU*CMT_W-1:0]   in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [CMT_W-1:0]      out_data;
  logic [1:0]            out_unit;
  logic [TB_CTR_W-1:0]   retired_cnt;
`ifdef COMMIT_PERF_EN
  logic [NU*TB_CTR_W-1:0] perf_stalls;
`endif
  commit_t od;
  assign od = out_data;

  int total;
  int bad;
  commit_t c1, b20, b21, b22, b00, b30, b11, b31, b32, b50, b51, b60;

  vx_commit_gather #(.NUM_UNITS(NU), .CTR_W(TB_CTR_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_unit    (out_unit),
    .retired_cnt (retired_cnt)
`ifdef COMMIT_PERF_EN
    ,
    .perf_stalls (perf_stalls)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cmt(input string tag, input commit_t obs, input commit_t exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed uuid=%0h tmask=%0h expected uuid=%0h tmask=%0h",
             tag, obs.uuid, obs.tmask, exp.uuid, exp.tmask);
    end
  endtask

  function automatic commit_t mk(input logic [UUID_W-1:0] uuid, input logic [3:0] tmask,
                                 input logic sop, input logic eop);
    commit_t c;
    c       = '0;
    c.uuid  = uuid;
    c.wid   = uuid[1:0];
    c.tmask = tmask;
    c.pc    = 32'h1000 + 32'(uuid[15:0]);
    c.wb    = 1'b1;
    c.rd    = uuid[5:0];
    for (int t = 0; t < int'(NUM_THREADS); t++) c.data[t] = {uuid[15:0], 16'(t)};
    c.sop   = sop;
    c.eop   = eop;
    return c;
  endfunction

  task automatic put(input int unsigned u, input commit_t c);
    in_data[u*CMT_W +: CMT_W] = c;
  endtask

  function automatic logic [63:0] wrap(input logic [63:0] x);
    logic [63:0] m;
    m = '1;
    if (TB_CTR_W < 64) m = (64'd1 << TB_CTR_W) - 64'd1;
    return x & m;
  endfunction

  task automatic rst_pulse();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    reset_n   = 1'b0;
    in_data   = '0;
    in_valid  = 4'hF;
    out_ready = 1'b0;

    // reset state, with every unit requesting
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_in_ready", 64'(in_ready), 64'h0);
    chk("rst_retired", 64'(retired_cnt), 64'h0);
    chk("rst_out_unit", 64'(out_unit), 64'h0);
    chk("rst_out_data_zero", 64'(out_data == '0), 64'h1);
    reset_n  = 1'b1;
    in_valid = '0;
    @(negedge clk);

    // single beat from unit 1
    c1 = mk(44'h1, 4'b1011, 1'b1, 1'b1);
    put(UNIT_LSU, c1);
    in_valid  = 4'b0010;
    out_ready = 1'b1;
    #1;
    chk("t1_in_ready", 64'(in_ready), 64'h2);
    @(negedge clk);
    chk("t1_out_valid", 64'(out_valid), 64'h1);
    chk("t1_out_unit", 64'(out_unit), 64'h1);
    chk_cmt("t1_out_data", od, c1);
    in_valid = '0;
    @(negedge clk);
    chk("t1_retired", 64'(retired_cnt), wrap(64'd3));
    chk("t1_drained", 64'(out_valid), 64'h0);

    // all units valid, round-robin from 0
    rst_pulse();
    put(UNIT_ALU, mk(44'h100, 4'hF, 1'b1, 1'b1));
    put(UNIT_LSU, mk(44'h101, 4'hF, 1'b1, 1'b1));
    put(UNIT_FPU, mk(44'h102, 4'hF, 1'b1, 1'b1));
    put(UNIT_SFU, mk(44'h103, 4'hF, 1'b1, 1'b1));
    in_valid = 4'hF;
    #1;
    for (int k = 0; k < 8; k++) begin
      if (k != 0) @(negedge clk);
      chk("t2_grant", 64'(in_ready), 64'd1 << (k % 4));
      if (k != 0) begin
        chk("t2_out_valid", 64'(out_valid), 64'h1);
        chk("t2_out_unit", 64'(out_unit), 64'((k - 1) % 4));
      end
    end
    in_valid = '0;
    @(negedge clk);
    chk("t2_drained", 64'(out_valid), 64'h0);
    chk("t2_retired", 64'(retired_cnt), wrap(64'd28));

    // unit 2 three-beat packet stays contiguous; pointer sits at 3
    b20 = mk(44'h20, 4'b0111, 1'b1, 1'b0);
    b21 = mk(44'h21, 4'b0111, 1'b0, 1'b0);
    b22 = mk(44'h22, 4'b0111, 1'b0, 1'b1);
    b00 = mk(44'h90, 4'b0000, 1'b1, 1'b1);
    b30 = mk(44'h30, 4'b0001, 1'b1, 1'b1);
    put(UNIT_FPU, b20);
    in_valid = 4'b0100;
    #1;
    chk("t3_first_beat", 64'(in_ready), 64'h4);
    @(negedge clk);
    chk("t3_out_valid_b0", 64'(out_valid), 64'h1);
    chk("t3_out_unit_b0", 64'(out_unit), 64'h2);
    chk_cmt("t3_out_b0", od, b20);
    put(UNIT_ALU, b00);
    put(UNIT_SFU, b30);
    in_valid = 4'b1001;
    #1;
    chk("t3_lock_hold", 64'(in_ready), 64'h0);
    @(negedge clk);
    chk("t3_gap", 64'(out_valid), 64'h0);
    put(UNIT_FPU, b21);
    in_valid = 4'b1101;
    #1;
    chk("t3_locked_b1", 64'(in_ready), 64'h4);
    @(negedge clk);
    chk_cmt("t3_out_b1", od, b21);
    put(UNIT_FPU, b22);
    #1;
    chk("t3_locked_b2", 64'(in_ready), 64'h4);
    @(negedge clk);
    chk_cmt("t3_out_b2", od, b22);
    in_valid = 4'b1001;
    #1;
    chk("t3_next_unit3", 64'(in_ready), 64'h8);
    @(negedge clk);
    chk_cmt("t3_out_u3", od, b30);
    chk("t3_out_unit_u3", 64'(out_unit), 64'h3);
    in_valid = 4'b0001;
    #1;
    chk("t3_next_unit0", 64'(in_ready), 64'h1);
    @(negedge clk);
    chk_cmt("t3_out_u0", od, b00);
    chk("t3_out_unit_u0", 64'(out_unit), 64'h0);
    in_valid = '0;
    @(negedge clk);
    chk("t3_drained", 64'(out_valid), 64'h0);
    chk("t3_retired", 64'(retired_cnt), wrap(64'd32));

    // back-pressure: buffer fills at two, head stays stable, drains in order
    b11 = mk(44'h11, 4'hF, 1'b1, 1'b1);
    b31 = mk(44'h31, 4'hF, 1'b1, 1'b1);
    b32 = mk(44'h32, 4'hF, 1'b1, 1'b1);
    out_ready = 1'b0;
    put(UNIT_LSU, b11);
    put(UNIT_SFU, b31);
    in_valid = 4'b1010;
    #1;
    chk("t4_grant_u1", 64'(in_ready), 64'h2);
    @(negedge clk);
    chk_cmt("t4_head_b11", od, b11);
    chk("t4_grant_u3", 64'(in_ready), 64'h8);
    in_valid = 4'b1000;
    @(negedge clk);
    chk("t4_full_ready", 64'(in_ready), 64'h0);
    chk_cmt("t4_stable1", od, b11);
    put(UNIT_SFU, b32);
    @(negedge clk);
    chk("t4_full_ready2", 64'(in_ready), 64'h0);
    chk("t4_out_valid_held", 64'(out_valid), 64'h1);
    chk_cmt("t4_stable2", od, b11);
    chk("t4_out_unit_held", 64'(out_unit), 64'h1);
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("t4_no_comb_path", 64'(in_ready), 64'h0);
    chk_cmt("t4_stable3", od, b11);
    @(negedge clk);
    chk_cmt("t4_out_b31", od, b31);
    chk("t4_out_unit_b31", 64'(out_unit), 64'h3);
    chk("t4_room_again", 64'(in_ready), 64'h8);
    @(negedge clk);
    chk_cmt("t4_out_b32", od, b32);
    in_valid = '0;
    @(negedge clk);
    chk("t4_drained", 64'(out_valid), 64'h0);
    chk("t4_retired", 64'(retired_cnt), wrap(64'd44));

    // reset in the middle of a packet discards lock and buffer
    b50 = mk(44'h50, 4'hF, 1'b1, 1'b0);
    b51 = mk(44'h51, 4'hF, 1'b0, 1'b0);
    b60 = mk(44'h60, 4'hF, 1'b1, 1'b1);
    put(UNIT_FPU, b50);
    in_valid = 4'b0100;
    #1;
    chk("t5_first_beat", 64'(in_ready), 64'h4);
    @(negedge clk);
    chk("t5_out_valid", 64'(out_valid), 64'h1);
    put(UNIT_FPU, b51);
    put(UNIT_ALU, b60);
    put(UNIT_LSU, b11);
    put(UNIT_SFU, b31);
    in_valid = 4'hF;
    reset_n  = 1'b0;
    #1;
    chk("t5_rst_out_valid", 64'(out_valid), 64'h0);
    chk("t5_rst_retired", 64'(retired_cnt), 64'h0);
    chk("t5_rst_in_ready", 64'(in_ready), 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("t5_ptr_zero_unlocked", 64'(in_ready), 64'h1);
    @(negedge clk);
    chk("t5_out_unit0", 64'(out_unit), 64'h0);
    chk_cmt("t5_out_b60", od, b60);
    in_valid = '0;
    @(negedge clk);

`ifdef COMMIT_PERF_EN
    // stall counting with a full buffer, then saturation
    rst_pulse();
    out_ready = 1'b0;
    put(UNIT_ALU, b60);
    in_valid = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    in_valid = 4'b1000;
    repeat (10) @(negedge clk);
    chk("t6_stall_u3", 64'(perf_stalls[3*TB_CTR_W +: TB_CTR_W]), 64'd10);
    chk("t6_stall_u0", 64'(perf_stalls[0 +: TB_CTR_W]), 64'd0);
    chk("t6_full_ready", 64'(in_ready), 64'h0);
    repeat (10) @(negedge clk);
    chk("t6_stall_sat", 64'(perf_stalls[3*TB_CTR_W +: TB_CTR_W]),
        (TB_CTR_W >= 5) ? 64'd20 : (64'd1 << TB_CTR_W) - 64'd1);
    in_valid = '0;
    @(negedge clk);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
